// File: rtl/mdu_pkg.sv
// mdu_pkg: shared M-extension funct3 encodings and dispatch FSM states
package mdu_pkg;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;
endpackage

// File: rtl/mdu_result_cache.sv
// mdu_result_cache: single-entry last-result cache keyed on operands, funct3 and word flag
module mdu_result_cache #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  output logic            hit,
  output logic [XLEN-1:0] hit_result,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [2:0]      wr_funct3,
  input  logic            wr_is_word,
  input  logic [XLEN-1:0] wr_result
);
  logic            valid;
  logic [XLEN-1:0] key_rs1, key_rs2, result;
  logic [2:0]      key_funct3;
  logic            key_is_word;
  assign hit = valid && key_rs1 == rs1 && key_rs2 == rs2 && key_funct3 == funct3 && key_is_word == is_word;
  assign hit_result = result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      key_rs1     <= '0;
      key_rs2     <= '0;
      key_funct3  <= '0;
      key_is_word <= 1'b0;
      result      <= '0;
    end else if (wr_en) begin
      valid       <= 1'b1;
      key_rs1     <= wr_rs1;
      key_rs2     <= wr_rs2;
      key_funct3  <= wr_funct3;
      key_is_word <= wr_is_word;
      result      <= wr_result;
    end
  end
endmodule

// File: rtl/mdu_dispatch_rv64.sv
// mdu_dispatch_rv64: EX-stage initiator issuing M-extension ops to the MDU and stalling until writeback
module mdu_dispatch_rv64
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_mdu_valid,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_word,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            flush,
  output logic            ex_stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mdu_req_valid,
  input  logic            mdu_req_ready,
  output logic [XLEN-1:0] mdu_rs1_data,
  output logic [XLEN-1:0] mdu_rs2_data,
  output logic [2:0]      mdu_funct3,
  output logic            mdu_is_word,
  input  logic            mdu_resp_valid,
  input  logic [XLEN-1:0] mdu_result
);
  state_t          state;
  logic            hit, accept, cache_wr;
  logic [XLEN-1:0] hit_result;
  assign accept   = state == S_IDLE && ex_mdu_valid && !flush;
  assign cache_wr = state == S_WAIT && mdu_resp_valid && !flush;
  assign ex_stall = ex_mdu_valid && !flush && state != S_DONE;
  mdu_result_cache #(.XLEN(XLEN)) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1        (ex_rs1_data),
    .rs2        (ex_rs2_data),
    .funct3     (ex_funct3),
    .is_word    (ex_is_word),
    .hit        (hit),
    .hit_result (hit_result),
    .wr_en      (cache_wr),
    .wr_rs1     (mdu_rs1_data),
    .wr_rs2     (mdu_rs2_data),
    .wr_funct3  (mdu_funct3),
    .wr_is_word (mdu_is_word),
    .wr_result  (mdu_result)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      mdu_req_valid <= 1'b0;
      mdu_rs1_data  <= '0;
      mdu_rs2_data  <= '0;
      mdu_funct3    <= '0;
      mdu_is_word   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          wb_rd <= ex_rd;
          if (ex_rd == 5'd0) begin
            state <= S_DONE;
          end else if (hit) begin
            wb_data  <= hit_result;
            wb_valid <= 1'b1;
            state    <= S_DONE;
          end else begin
            mdu_rs1_data  <= ex_rs1_data;
            mdu_rs2_data  <= ex_rs2_data;
            mdu_funct3    <= ex_funct3;
            mdu_is_word   <= ex_is_word;
            mdu_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: if (mdu_req_ready || flush) begin
          mdu_req_valid <= 1'b0;
          state         <= mdu_req_ready ? (flush ? S_DRAIN : S_WAIT) : S_IDLE;
        end
        S_WAIT: if (mdu_resp_valid) begin
          wb_data  <= flush ? wb_data : mdu_result;
          wb_valid <= !flush;
          state    <= flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state <= S_DRAIN;
        end
        S_DONE:  state <= S_IDLE;
        S_DRAIN: state <= mdu_resp_valid ? S_IDLE : S_DRAIN;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_dispatch_rv64.sv
// tb_mdu_dispatch_rv64: directed self-checking bench for the MDU dispatch stage
module tb_mdu_dispatch_rv64;
  import mdu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mdu_valid, ex_is_word, flush;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [63:0] ex_rs1_data, ex_rs2_data;
  logic        ex_stall, wb_valid, mdu_req_valid, mdu_req_ready, mdu_is_word, mdu_resp_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, mdu_rs1_data, mdu_rs2_data, mdu_result;
  logic [2:0]  mdu_funct3;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [63:0] M3 = 64'hFFFF_FFFF_FFFF_FFFD;
  always #5 clk = ~clk;
  mdu_dispatch_rv64 #(.XLEN(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_mdu_valid   (ex_mdu_valid),
    .ex_funct3      (ex_funct3),
    .ex_is_word     (ex_is_word),
    .ex_rd          (ex_rd),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .mdu_req_valid  (mdu_req_valid),
    .mdu_req_ready  (mdu_req_ready),
    .mdu_rs1_data   (mdu_rs1_data),
    .mdu_rs2_data   (mdu_rs2_data),
    .mdu_funct3     (mdu_funct3),
    .mdu_is_word    (mdu_is_word),
    .mdu_resp_valid (mdu_resp_valid),
    .mdu_result     (mdu_result)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [2:0] f3, input logic w, input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
    ex_mdu_valid = 1'b1;
    ex_funct3    = f3;
    ex_is_word   = w;
    ex_rd        = rd;
    ex_rs1_data  = a;
    ex_rs2_data  = b;
  endtask
  task automatic op(input string name, input logic [2:0] f3, input logic w, input logic [4:0] rd,
                    input logic [63:0] a, input logic [63:0] b, input int resp_cyc,
                    input logic exp_wb, input logic [63:0] res);
    int done;
    done = resp_cyc < 0 ? 1 : resp_cyc + 1;
    set_op(f3, w, rd, a, b);
    for (int c = 0; c <= done; c++) begin
      mdu_resp_valid = (c == resp_cyc);
      mdu_result     = (c == resp_cyc) ? res : 64'h0;
      #1;
      chk($sformatf("%s c%0d stall", name, c), ex_stall, c < done);
      chk($sformatf("%s c%0d req", name, c), mdu_req_valid, resp_cyc >= 0 && c == 1);
      chk($sformatf("%s c%0d wb_valid", name, c), wb_valid, exp_wb && c == done);
      if (c == 1 && resp_cyc >= 0) begin
        chk($sformatf("%s mdu_rs1", name), mdu_rs1_data, a);
        chk($sformatf("%s mdu_rs2", name), mdu_rs2_data, b);
        chk($sformatf("%s mdu_funct3", name), mdu_funct3, f3);
        chk($sformatf("%s mdu_is_word", name), mdu_is_word, w);
      end
      if (c == done && exp_wb) begin
        chk($sformatf("%s wb_rd", name), wb_rd, rd);
        chk($sformatf("%s wb_data", name), wb_data, res);
      end
      cyc();
    end
    ex_mdu_valid   = 1'b0;
    mdu_resp_valid = 1'b0;
    #1;
    chk($sformatf("%s after wb_valid", name), wb_valid, 1'b0);
    chk($sformatf("%s after stall", name), ex_stall, 1'b0);
    cyc();
  endtask
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    mdu_req_ready = 1'b1;
    mdu_resp_valid = 1'b0;
    mdu_result = '0;
    set_op(3'd0, 1'b0, 5'd0, 64'h0, 64'h0);
    ex_mdu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst stall", ex_stall, 1'b0);
    chk("rst wb_valid", wb_valid, 1'b0);
    chk("rst req", mdu_req_valid, 1'b0);
    chk("rst wb_rd", wb_rd, 5'd0);
    chk("rst wb_data", wb_data, 64'h0);
    chk("rst mdu_rs1", mdu_rs1_data, 64'h0);
    rst_n = 1'b1;
    cyc();
    op("mul", F3_MUL, 1'b0, 5'd5, 64'd7, M3, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    op("mul_hit", F3_MUL, 1'b0, 5'd5, 64'd7, M3, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    op("mulh", F3_MULH, 1'b0, 5'd5, 64'd7, M3, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    op("divu0", F3_DIVU, 1'b0, 5'd6, 64'd100, 64'd0, 9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    set_op(F3_DIV, 1'b0, 5'd4, 64'd1000, 64'd7);
    #1;
    chk("div c0 stall", ex_stall, 1'b1);
    cyc();
    #1;
    chk("div c1 req", mdu_req_valid, 1'b1);
    cyc();
    for (int c = 2; c <= 10; c++) begin
      #1;
      chk($sformatf("div c%0d stall", c), ex_stall, 1'b1);
      chk($sformatf("div c%0d req", c), mdu_req_valid, 1'b0);
      cyc();
    end
    flush = 1'b1;
    #1;
    chk("div flush stall", ex_stall, 1'b0);
    cyc();
    flush = 1'b0;
    set_op(F3_MUL, 1'b0, 5'd7, 64'd2, 64'd3);
    for (int c = 12; c <= 15; c++) begin
      mdu_resp_valid = (c == 15);
      mdu_result     = (c == 15) ? 64'd142 : 64'h0;
      #1;
      chk($sformatf("drain c%0d stall", c), ex_stall, 1'b1);
      chk($sformatf("drain c%0d wb_valid", c), wb_valid, 1'b0);
      chk($sformatf("drain c%0d req", c), mdu_req_valid, 1'b0);
      cyc();
    end
    mdu_resp_valid = 1'b0;
    op("mul_after_drain", F3_MUL, 1'b0, 5'd7, 64'd2, 64'd3, 5, 1'b1, 64'd6);
    mdu_req_ready = 1'b0;
    set_op(F3_MULHU, 1'b0, 5'd3, 64'd9, 64'd9);
    cyc();
    #1;
    chk("reqflush c1 req", mdu_req_valid, 1'b1);
    cyc();
    #1;
    chk("reqflush c2 req held", mdu_req_valid, 1'b1);
    flush = 1'b1;
    #1;
    chk("reqflush c2 stall", ex_stall, 1'b0);
    cyc();
    flush = 1'b0;
    ex_mdu_valid = 1'b0;
    mdu_req_ready = 1'b1;
    #1;
    chk("reqflush c3 req", mdu_req_valid, 1'b0);
    chk("reqflush c3 wb_valid", wb_valid, 1'b0);
    cyc();
    op("mulw_x0", F3_MUL, 1'b1, 5'd0, 64'd4, 64'd5, -1, 1'b0, 64'h0);
    set_op(F3_MULHU, 1'b0, 5'd9, 64'd5, 64'd6);
    cyc();
    #1;
    chk("rstop c1 req", mdu_req_valid, 1'b1);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    ex_mdu_valid = 1'b0;
    #1;
    chk("midrst stall", ex_stall, 1'b0);
    chk("midrst wb_valid", wb_valid, 1'b0);
    chk("midrst req", mdu_req_valid, 1'b0);
    chk("midrst wb_rd", wb_rd, 5'd0);
    chk("midrst wb_data", wb_data, 64'h0);
    chk("midrst mdu_rs1", mdu_rs1_data, 64'h0);
    chk("midrst mdu_rs2", mdu_rs2_data, 64'h0);
    chk("midrst mdu_funct3", mdu_funct3, 3'd0);
    chk("midrst mdu_is_word", mdu_is_word, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    op("mul_after_rst", F3_MUL, 1'b0, 5'd7, 64'd2, 64'd3, 5, 1'b1, 64'd6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
